// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and address helper for the register file bank
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    // DEPTH need not be a power of two, so an address that fits ADDR_W may still miss the array
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// rtl/reg_file_read_port.sv - one registered, write-first read port of the register file bank
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [WIDTH-1:0]  mem [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid
);

    logic             in_range;
    logic             bypass;
    logic [WIDTH-1:0] next_data;
    logic             next_valid;

    assign in_range = addr_in_range(32'(rd_addr), DEPTH);
    // wr_ok already excludes clear and out-of-range writes, so a match here is always a real write
    assign bypass   = wr_ok && (wr_addr == rd_addr);

    // Select what this port would return: clear wins, then same-cycle write data, then stored entry
    always_comb begin
        next_data  = '0;
        next_valid = 1'b0;
        if (clr) begin
            next_data  = '0;
            next_valid = 1'b0;
        end else if (bypass) begin
            next_data  = wr_data;
            next_valid = 1'b1;
        end else if (in_range && valid[rd_addr]) begin
            next_data  = mem[rd_addr];
            next_valid = 1'b1;
        end
    end

    // Output register loads only on a read strobe and otherwise holds the last result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= next_data;
            rd_valid <= next_valid;
        end
    end

endmodule

// File: rtl/reg_file_bank.sv
// rtl/reg_file_bank.sv - DEPTH x WIDTH register file, one write port, two registered read ports
module reg_file_bank
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             wr_ok;

    // A write takes effect only when not cleared and aimed inside the array
    assign wr_ok = wr_en && !clr && addr_in_range(32'(wr_addr), DEPTH);

    // Storage and valid vector: reset and clear wipe everything, otherwise accept a qualified write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid <= '0;
        end else if (wr_ok) begin
            mem[wr_addr]   <= wr_data;
            valid[wr_addr] <= 1'b1;
        end
    end

    reg_file_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .rd_en    (rd_en_a),
        .rd_addr  (rd_addr_a),
        .wr_ok    (wr_ok),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .mem      (mem),
        .valid    (valid),
        .rd_data  (rd_data_a),
        .rd_valid (rd_valid_a)
    );

    reg_file_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .rd_en    (rd_en_b),
        .rd_addr  (rd_addr_b),
        .wr_ok    (wr_ok),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .mem      (mem),
        .valid    (valid),
        .rd_data  (rd_data_b),
        .rd_valid (rd_valid_b)
    );

endmodule

// File: tb/tb_reg_file_bank.sv
// tb/tb_reg_file_bank.sv - directed vector bench for reg_file_bank at DEPTH 8 and DEPTH 6
module tb_reg_file_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en_a = 1'b0;
    logic [2:0] rd_addr_a = '0;
    logic       rd_en_b = 1'b0;
    logic [2:0] rd_addr_b = '0;

    logic [7:0] rd_data_a, rd_data_b, rd_data_a6, rd_data_b6;
    logic       rd_valid_a, rd_valid_b, rd_valid_a6, rd_valid_b6;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_file_bank #(.WIDTH(8), .DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
    );

    reg_file_bank #(.WIDTH(8), .DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a6), .rd_valid_a(rd_valid_a6),
        .rd_data_b(rd_data_b6), .rd_valid_b(rd_valid_b6)
    );

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       ea;
        logic [2:0] aa;
        logic       eb;
        logic [2:0] ab;
        logic [7:0] xa;
        logic       xva;
        logic [7:0] xb;
        logic       xvb;
    } vec_t;

    vec_t vecs [8];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'd2, 8'hFA, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd5, 8'hFA, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 3'd4, 8'h0F, 1'b1, 3'd4, 1'b0, 3'd0, 8'h0F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 3'd4, 8'h33, 1'b0, 3'd4, 1'b0, 3'd0, 8'h0F, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd4, 8'h0F, 1'b1, 8'h33, 1'b1};
        vecs[5] = '{1'b1, 3'd0, 8'hAA, 1'b1, 3'd0, 1'b1, 3'd0, 8'hAA, 1'b1, 8'hAA, 1'b1};
        vecs[6] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0, 8'hAA, 1'b1, 8'hAA, 1'b1};
        vecs[7] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b1, 3'd2, 8'h00, 1'b0, 8'hFA, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check8("reset rd_data_a", rd_data_a, 8'h00);
        check1("reset rd_valid_a", rd_valid_a, 1'b0);
        check8("reset rd_data_b", rd_data_b, 8'h00);
        check1("reset rd_valid_b", rd_valid_b, 1'b0);
        rst = 1'b0;

        // Table: write/readback, hold, bypass, dual-port same address, unwritten entry
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ea, vecs[i].aa, vecs[i].eb, vecs[i].ab);
            step();
            check8($sformatf("vec%0d rd_data_a", i), rd_data_a, vecs[i].xa);
            check1($sformatf("vec%0d rd_valid_a", i), rd_valid_a, vecs[i].xva);
            check8($sformatf("vec%0d rd_data_b", i), rd_data_b, vecs[i].xb);
            check1($sformatf("vec%0d rd_valid_b", i), rd_valid_b, vecs[i].xvb);
        end

        // Clear priority: fill 0..7, confirm, then clr with a coincident write and reads
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 8'h10 + 8'(i), 1'b0, 3'd0, 1'b0, 3'd0);
            step();
        end
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd7);
        step();
        check8("prefill a addr3", rd_data_a, 8'h13);
        check8("prefill b addr7", rd_data_b, 8'h17);
        drive(1'b1, 3'd1, 8'hAA, 1'b1, 3'd1, 1'b1, 3'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check8("clr-cycle a data", rd_data_a, 8'h00);
        check1("clr-cycle a valid", rd_valid_a, 1'b0);
        check8("clr-cycle b data", rd_data_b, 8'h00);
        check1("clr-cycle b valid", rd_valid_b, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i));
            step();
            check8($sformatf("post-clr a addr%0d", i), rd_data_a, 8'h00);
            check1($sformatf("post-clr a valid%0d", i), rd_valid_a, 1'b0);
            check1($sformatf("post-clr b valid%0d", 7 - i), rd_valid_b, 1'b0);
        end

        // Out-of-range on the DEPTH 6 instance
        drive(1'b1, 3'd5, 8'h22, 1'b0, 3'd0, 1'b0, 3'd0);
        step();
        drive(1'b1, 3'd6, 8'h55, 1'b0, 3'd0, 1'b0, 3'd0);
        step();
        drive(1'b1, 3'd7, 8'h55, 1'b1, 3'd7, 1'b1, 3'd5);
        step();
        check8("d6 oor bypass a data", rd_data_a6, 8'h00);
        check1("d6 oor bypass a valid", rd_valid_a6, 1'b0);
        check8("d6 addr5 data", rd_data_b6, 8'h22);
        check1("d6 addr5 valid", rd_valid_b6, 1'b1);
        check8("d8 addr7 bypass data", rd_data_a, 8'h55);
        check1("d8 addr7 bypass valid", rd_valid_a, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1, 3'd7);
        step();
        check1("d6 read addr6 valid", rd_valid_a6, 1'b0);
        check8("d6 read addr7 data", rd_data_b6, 8'h00);
        check1("d6 read addr7 valid", rd_valid_b6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0, 3'd0);
            step();
            check1($sformatf("d6 no alias addr%0d", i), rd_valid_a6, 1'b0);
        end

        // Asynchronous reset mid-run
        drive(1'b1, 3'd3, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0);
        step();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd5);
        step();
        check8("pre-rst a addr3", rd_data_a, 8'h3C);
        check8("pre-rst b addr5", rd_data_b, 8'h22);
        idle();
        #3;
        rst = 1'b1;
        #1;
        check8("async rst a data", rd_data_a, 8'h00);
        check1("async rst a valid", rd_valid_a, 1'b0);
        check8("async rst b data", rd_data_b, 8'h00);
        check1("async rst b valid", rd_valid_b, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd5);
        step();
        check8("post-rst a addr3 data", rd_data_a, 8'h00);
        check1("post-rst a addr3 valid", rd_valid_a, 1'b0);
        check1("post-rst b addr5 valid", rd_valid_b, 1'b0);
        check1("post-rst d6 addr5 valid", rd_valid_b6, 1'b0);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
